serial_adder_nbit: RTL and testbench

//   Bit-serial N-bit adder: adds operands a + b + cin one bit per clock, LSB first,

---
 rtl/serial_adder_nbit.sv | 123 ++++++++++++
 tb/tb_serial_adder_nbit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_nbit.sv
// serial_adder_nbit
//   Bit-serial adder. It computes {cout, sum} = a + b + cin one bit per clock,
//   LSB first, using one carry flop. A start/done handshake connects it to an
//   operand source and a result consumer. A new request can be accepted in
//   the DONE cycle, so operations can run back to back.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high
//   start  in   request; honoured only in IDLE or DONE
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   busy   out  high while an addition is in progress
//   done   out  one-cycle pulse; sum/cout were just updated
//   sum    out  WIDTH-bit result, held until the next completion
//   cout   out  carry-out of the MSB, held with sum
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | one operand bit pair consumed per clock
// S_DONE | result published this cycle; start may reload immediately
module serial_adder_nbit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    count;

    logic             accept;
    logic             last_bit;
    logic             bit_s;
    logic             carry_nxt;
    logic [WIDTH-1:0] acc_nxt;

    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign last_bit  = (state == S_RUN) && (count == LAST);

    // Full-adder slice on the current LSBs. The new sum bit enters the top
    // of acc, so after WIDTH shifts bit 0 of the result ends up at acc[0].
    assign bit_s     = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    assign acc_nxt   = {bit_s, acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_bit) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    // sum/cout load only on the completion edge. Consumers therefore never
    // see a partial result while acc is still filling.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            acc   <= '0;
            carry <= cin;
            count <= '0;
        end else if (state == S_RUN) begin
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            acc   <= acc_nxt;
            carry <= carry_nxt;
            count <= count + CW'(1);
            if (last_bit) begin
                sum  <= acc_nxt;
                cout <= carry_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_nbit.sv
module tb_serial_adder_nbit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_nbit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    serial_adder_nbit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic c);
        start4 = 1'b1; a4 = a; b4 = b; cin4 = c;
        step();
        start4 = 1'b0;
    endtask

    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
        start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        step();
        start8 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy4, done4, cout4, sum4} !== 7'b0) begin
            errors++;
            $display("FAIL reset4 got busy=%b done=%b cout=%b sum=%h want all 0", busy4, done4, cout4, sum4);
        end
        checks++;
        if ({busy8, done8, cout8, sum8} !== 11'b0) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b cout=%b sum=%h want all 0", busy8, done8, cout8, sum8);
        end
    endtask

    // T1: 7 + 9 + 0 = 16 -> sum 0, cout 1, latency 4, busy for 4 cycles
    task automatic test_basic();
        int n = 0;
        int busy_cnt = 0;
        go4(4'd7, 4'd9, 1'b0);
        while (!done4 && n < 20) begin
            if (busy4) busy_cnt++;
            step();
            n++;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL basic_latency got %0d want 4", n);
        end
        checks++;
        if (busy_cnt !== 4) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d want 4", busy_cnt);
        end
        checks++;
        if ({cout4, sum4} !== 5'h10) begin
            errors++;
            $display("FAIL basic_result got %h want 10", {cout4, sum4});
        end
        step();
        checks++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", done4, busy4);
        end
    endtask

    // T2: all-ones with carry-in, then all-zeros
    task automatic test_extremes();
        int n = 0;
        go4(4'hF, 4'hF, 1'b1);
        while (!done4 && n < 20) begin step(); n++; end
        checks++;
        if ({cout4, sum4} !== 5'h1F) begin
            errors++;
            $display("FAIL extremes_max got %h want 1f", {cout4, sum4});
        end
        step();
        n = 0;
        go4(4'h0, 4'h0, 1'b0);
        while (!done4 && n < 20) begin step(); n++; end
        checks++;
        if ({cout4, sum4} !== 5'h00 || n !== 4) begin
            errors++;
            $display("FAIL extremes_zero got %h lat %0d want 00 lat 4", {cout4, sum4}, n);
        end
    endtask

    // T3: a second start during RUN must be ignored
    task automatic test_start_ignored();
        int n = 0;
        go4(4'd3, 4'd4, 1'b0);
        step();
        start4 = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        step();
        start4 = 1'b0;
        n = 2;
        while (!done4 && n < 20) begin step(); n++; end
        checks++;
        if ({cout4, sum4} !== 5'h07 || n !== 4) begin
            errors++;
            $display("FAIL start_ignored got %h lat %0d want 07 lat 4", {cout4, sum4}, n);
        end
        step();
        checks++;
        if (busy4 !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_idle got busy=%b want 0", busy4);
        end
    endtask

    // T4: reset in the second RUN cycle aborts without a done pulse
    task automatic test_reset_mid_run();
        logic saw_done = 1'b0;
        go4(4'd5, 4'd6, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({busy4, done4, cout4, sum4} !== 7'b0) begin
            errors++;
            $display("FAIL mid_run_reset got busy=%b done=%b cout=%b sum=%h want all 0", busy4, done4, cout4, sum4);
        end
        for (int i = 0; i < 8; i++) begin
            if (done4 || busy4) saw_done = 1'b1;
            step();
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_no_done got activity=%b want 0", saw_done);
        end
    endtask

    // T5: start held through DONE reloads directly; done pulses 5 cycles apart
    task automatic test_back_to_back();
        int n = 0;
        start4 = 1'b1; a4 = 4'd10; b4 = 4'd11; cin4 = 1'b1;
        step();
        while (!done4 && n < 20) begin step(); n++; end
        checks++;
        if ({cout4, sum4} !== 5'h16) begin
            errors++;
            $display("FAIL b2b_first got %h want 16", {cout4, sum4});
        end
        a4 = 4'd2; b4 = 4'd9; cin4 = 1'b0;
        step();
        start4 = 1'b0;
        checks++;
        if (busy4 !== 1'b1 || done4 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reenter got busy=%b done=%b want 1 0", busy4, done4);
        end
        n = 1;
        while (!done4 && n < 20) begin step(); n++; end
        checks++;
        if (n !== 5 || {cout4, sum4} !== 5'h0B) begin
            errors++;
            $display("FAIL b2b_second got %h gap %0d want 0b gap 5", {cout4, sum4}, n);
        end
        step();
    endtask

    // T6a: every WIDTH=4 input; issued back to back from DONE
    task automatic test_exhaustive4();
        logic [4:0] prev = 5'h00;
        logic [4:0] expv;
        logic       bad;
        int         n;
        do_reset();
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            expv = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
            go4(v[3:0], v[7:4], v[8]);
            n = 0;
            bad = 1'b0;
            while (!done4 && n < 20) begin
                if (busy4 && done4) bad = 1'b1;
                if ({cout4, sum4} !== prev) bad = 1'b1;
                step();
                n++;
            end
            if (busy4 && done4) bad = 1'b1;
            checks++;
            if (bad || n !== 4 || {cout4, sum4} !== expv) begin
                errors++;
                $display("FAIL exh4 a=%h b=%h cin=%b got %h lat %0d glitch %b want %h lat 4",
                         v[3:0], v[7:4], v[8], {cout4, sum4}, n, bad, expv);
            end
            prev = expv;
        end
        step();
    endtask

    // T6b: WIDTH=8 corners plus random operands
    task automatic test_random8();
        logic [8:0] prev = 9'h000;
        logic [8:0] expv;
        logic [7:0] ra, rb;
        logic       rc;
        logic       bad;
        int         n;
        for (int i = 0; i < 120; i++) begin
            if (i == 0) begin ra = 8'hFF; rb = 8'hFF; rc = 1'b1; end
            else if (i == 1) begin ra = 8'h80; rb = 8'h80; rc = 1'b0; end
            else if (i == 2) begin ra = 8'hFF; rb = 8'h00; rc = 1'b1; end
            else begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                rc = 1'($urandom_range(0, 1));
            end
            expv = 9'(ra) + 9'(rb) + 9'(rc);
            go8(ra, rb, rc);
            n = 0;
            bad = 1'b0;
            while (!done8 && n < 30) begin
                if (busy8 && done8) bad = 1'b1;
                if ({cout8, sum8} !== prev) bad = 1'b1;
                step();
                n++;
            end
            checks++;
            if (bad || n !== 8 || {cout8, sum8} !== expv) begin
                errors++;
                $display("FAIL rnd8 a=%h b=%h cin=%b got %h lat %0d glitch %b want %h lat 8",
                         ra, rb, rc, {cout8, sum8}, n, bad, expv);
            end
            prev = expv;
            if (i % 3 == 0) step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_exhaustive4();
        test_random8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
